// File: rtl/hyper_chip_decoder.sv
// Address decoder that maps requests onto (phy, chip, offset) through a shadow/active rule table.
// Rule updates are committed atomically once all outstanding traffic has drained.
module hyper_chip_decoder #(
    parameter int unsigned NumPhys      = 32'd1,
    parameter int unsigned NumChips     = 32'd2,
    parameter int unsigned AddrWidth    = 32'd48,
    parameter logic [63:0] MemBase      = 64'h8000_0000,
    parameter logic [63:0] RstChipBytes = 64'h80_0000,
    parameter int unsigned MaxTxns      = 32'd8,
    localparam int unsigned NumRules    = NumPhys * NumChips,
    localparam int unsigned PhyW        = (NumPhys > 32'd1) ? $clog2(NumPhys) : 32'd1,
    localparam int unsigned ChipW       = (NumChips > 32'd1) ? $clog2(NumChips) : 32'd1,
    localparam int unsigned CfgAW       = $clog2(2 * NumRules + 2),
    localparam int unsigned CntW        = $clog2(MaxTxns + 2)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [AddrWidth-1:0] in_addr_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PhyW-1:0]      out_phy_o,
    output logic [ChipW-1:0]     out_chip_o,
    output logic [AddrWidth-1:0] out_offset_o,
    output logic                 out_err_o,
    input  logic                 rsp_done_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [CfgAW-1:0]     cfg_addr_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_gnt_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 busy_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDrain = 2'd1;
    localparam logic [1:0] StSwap  = 2'd2;

    function automatic logic [AddrWidth-1:0] rst_start(input int r);
        logic [63:0] v;
        v = MemBase + RstChipBytes * 64'(r);
        return AddrWidth'(v);
    endfunction

    logic [AddrWidth-1:0] sh_start_q  [NumRules];
    logic [AddrWidth-1:0] sh_end_q    [NumRules];
    logic [AddrWidth-1:0] act_start_q [NumRules];
    logic [AddrWidth-1:0] act_end_q   [NumRules];

    logic [1:0]           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 out_valid_q, out_err_q;
    logic [PhyW-1:0]      out_phy_q;
    logic [ChipW-1:0]     out_chip_q;
    logic [AddrWidth-1:0] out_offset_q;
    logic                 cfg_gnt_q;
    logic [AddrWidth-1:0] cfg_rdata_q;

    logic                 match_s, hit_s, in_accept_s;
    logic [PhyW-1:0]      dec_phy_s;
    logic [ChipW-1:0]     dec_chip_s;
    logic [AddrWidth-1:0] dec_off_s;
    logic                 cfg_acc_s, cfg_commit_s, inc_s, dec_s;
    logic [AddrWidth-1:0] cfg_rd_s;

    assign busy_o       = (state_q != StIdle);
    assign in_ready_o   = (!out_valid_q || out_ready_i) && (state_q == StIdle) &&
                          (cnt_q != CntW'(MaxTxns));
    assign in_accept_s  = in_valid_i && in_ready_o;
    assign out_valid_o  = out_valid_q;
    assign out_phy_o    = out_phy_q;
    assign out_chip_o   = out_chip_q;
    assign out_offset_o = out_offset_q;
    assign out_err_o    = out_err_q;
    assign cfg_gnt_o    = cfg_gnt_q;
    assign cfg_rdata_o  = cfg_rdata_q;
    assign cfg_acc_s    = cfg_req_i && !cfg_gnt_q;
    assign cfg_commit_s = cfg_acc_s && cfg_we_i && (cfg_addr_i == CfgAW'(2 * NumRules));

    // Rule match; scanning downwards lets the lowest matching rule win.
    always_comb begin
        match_s    = 1'b0;
        hit_s      = 1'b0;
        dec_phy_s  = '0;
        dec_chip_s = '0;
        dec_off_s  = '0;
        for (int r = int'(NumRules) - 1; r >= 0; r--) begin
            match_s    = (act_start_q[r] <= in_addr_i) && (in_addr_i < act_end_q[r]);
            hit_s      = hit_s | match_s;
            dec_phy_s  = match_s ? PhyW'(r / int'(NumChips)) : dec_phy_s;
            dec_chip_s = match_s ? ChipW'(r % int'(NumChips)) : dec_chip_s;
            dec_off_s  = match_s ? (in_addr_i - act_start_q[r]) : dec_off_s;
        end
    end

    // Single output register; holds its contents while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
            out_phy_q    <= '0;
            out_chip_q   <= '0;
            out_offset_q <= '0;
        end else if (in_accept_s) begin
            out_valid_q  <= 1'b1;
            out_err_q    <= ~hit_s;
            out_phy_q    <= dec_phy_s;
            out_chip_q   <= dec_chip_s;
            out_offset_q <= dec_off_s;
        end else if (out_ready_i) begin
            out_valid_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_q;
        end
    end

    // Outstanding counter; a completion at zero is ignored.
    always_comb begin
        inc_s = out_valid_q && out_ready_i && !out_err_q;
        dec_s = rsp_done_i && (cnt_q != '0);
        case ({inc_s, dec_s})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Commit sequencing: wait for in-flight work to finish before swapping the table.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cfg_commit_s) state_d = StDrain;
                else              state_d = StIdle;
            end
            StDrain: begin
                if ((cnt_q == '0) && !out_valid_q) state_d = StSwap;
                else                               state_d = StDrain;
            end
            StSwap:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Config read mux.
    always_comb begin
        cfg_rd_s = '0;
        for (int r = 0; r < int'(NumRules); r++) begin
            cfg_rd_s = (cfg_addr_i == CfgAW'(2 * r))     ? sh_start_q[r] : cfg_rd_s;
            cfg_rd_s = (cfg_addr_i == CfgAW'(2 * r + 1)) ? sh_end_q[r]   : cfg_rd_s;
        end
        if (cfg_addr_i == CfgAW'(2 * NumRules)) begin
            cfg_rd_s = {{(AddrWidth - 1){1'b0}}, busy_o};
        end else if (cfg_addr_i == CfgAW'(2 * NumRules + 1)) begin
            cfg_rd_s = AddrWidth'(cnt_q);
        end else begin
            cfg_rd_s = cfg_rd_s;
        end
    end

    // Config response: one-cycle grant carrying the read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_gnt_q   <= 1'b0;
            cfg_rdata_q <= '0;
        end else begin
            cfg_gnt_q   <= cfg_acc_s;
            cfg_rdata_q <= cfg_acc_s ? cfg_rd_s : '0;
        end
    end

    // Rule tables; the swap copies pre-write shadow contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < int'(NumRules); r++) begin
                sh_start_q[r]  <= rst_start(r);
                sh_end_q[r]    <= rst_start(r) + AddrWidth'(RstChipBytes);
                act_start_q[r] <= rst_start(r);
                act_end_q[r]   <= rst_start(r) + AddrWidth'(RstChipBytes);
            end
        end else begin
            for (int r = 0; r < int'(NumRules); r++) begin
                if (cfg_acc_s && cfg_we_i && (cfg_addr_i == CfgAW'(2 * r))) begin
                    sh_start_q[r] <= cfg_wdata_i;
                end else if (cfg_acc_s && cfg_we_i && (cfg_addr_i == CfgAW'(2 * r + 1))) begin
                    sh_end_q[r] <= cfg_wdata_i;
                end else begin
                    sh_start_q[r] <= sh_start_q[r];
                end
                if (state_q == StSwap) begin
                    act_start_q[r] <= sh_start_q[r];
                    act_end_q[r]   <= sh_end_q[r];
                end else begin
                    act_start_q[r] <= act_start_q[r];
                end
            end
        end
    end

endmodule
